// File: rtl/gnw_loader.sv
// gnw_loader
// Sequences the Game & Watch BIN download coming from hps_io. The stream is
// split into three consecutive regions:
//   [0 .. HDR_BYTES-1]            header: mcuid, then 12 joystick-mapping bytes
//   [.. +2*SCREENSIZE-1]          LCD image, written to SDRAM with a wait handshake
//   [.. +ROM_BYTES-1]             SM510 program ROM, written to the MCU rom_init port
// Addresses must arrive strictly in order; the end of the download is checked
// for completeness and the result is reported on cfg_valid_o / err_o.
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   dl_active_i           ioctl_download
//   dl_wr_i               ioctl_wr byte strobe
//   dl_addr_i, dl_data_i  ioctl_addr / ioctl_dout
//   dl_wait_o             ioctl_wait, high while an SDRAM write is outstanding
//   sdram_we_o            one-cycle write request, sdram_addr_o / sdram_din_o
//   sdram_ack_i           one-cycle write-complete pulse
//   rom_we_o              one-cycle ROM write, rom_addr_o / rom_data_o
//   mcuid_o, joy_cfg_o    header contents
//   cfg_valid_o           last download completed cleanly
//   err_o                 0 none, 1 out-of-order, 2 short file, 3 overrun
module gnw_loader #(
  parameter int SCREENSIZE = 307200,
  parameter int HDR_BYTES  = 13,
  parameter int ROM_BYTES  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dl_active_i,
  input  logic        dl_wr_i,
  input  logic [24:0] dl_addr_i,
  input  logic [7:0]  dl_data_i,
  output logic        dl_wait_o,
  output logic        sdram_we_o,
  output logic [24:0] sdram_addr_o,
  output logic [7:0]  sdram_din_o,
  input  logic        sdram_ack_i,
  output logic        rom_we_o,
  output logic [11:0] rom_addr_o,
  output logic [7:0]  rom_data_o,
  output logic [7:0]  mcuid_o,
  output logic [95:0] joy_cfg_o,
  output logic        cfg_valid_o,
  output logic [1:0]  err_o
);

  localparam logic [24:0] HDR_LAST = 25'(HDR_BYTES - 1);
  localparam logic [24:0] SCR_END  = 25'(HDR_BYTES + 2 * SCREENSIZE);
  localparam logic [24:0] TOTAL    = 25'(HDR_BYTES + 2 * SCREENSIZE + ROM_BYTES);
  localparam logic [24:0] ROM_LEN  = 25'(ROM_BYTES);
  localparam logic [24:0] EXP_MAX  = 25'h1FF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_SCREEN = 3'd2,
    ST_ROM    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        active_q;
  logic [24:0] exp_q, exp_d;
  logic        wait_q, wait_d;
  logic        end_pend_q, end_pend_d;
  logic        sdram_we_q, sdram_we_d;
  logic [24:0] sdram_addr_q, sdram_addr_d;
  logic [7:0]  sdram_din_q, sdram_din_d;
  logic        rom_we_q, rom_we_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic [7:0]  mcuid_q, mcuid_d;
  logic [95:0] joy_q, joy_d;
  logic        cfg_valid_q, cfg_valid_d;
  logic [1:0]  err_q, err_d;

  // A start overrides whatever state we were in: the cycle is processed as if
  // already in HEADER with exp=0, so a byte arriving with the rising edge of
  // dl_active becomes header byte 0.
  logic        start_s, fall_s, loading_s, byte_s;
  logic        overrun_s, good_s, bad_s, ack_s, end_now_s, complete_s, rom_hit_s;
  state_e      st_eff_s;
  logic [24:0] exp_eff_s, rom_off_s;

  assign start_s    = dl_active_i & ~active_q;
  assign fall_s     = ~dl_active_i & active_q;
  assign st_eff_s   = start_s ? ST_HEADER : state_q;
  assign exp_eff_s  = start_s ? 25'd0 : exp_q;
  assign loading_s  = (st_eff_s == ST_HEADER) | (st_eff_s == ST_SCREEN) | (st_eff_s == ST_ROM);
  assign byte_s     = dl_wr_i & dl_active_i & loading_s;
  assign overrun_s  = byte_s & wait_q;
  assign good_s     = byte_s & ~wait_q & (dl_addr_i == exp_eff_s);
  assign bad_s      = byte_s & ~wait_q & (dl_addr_i != exp_eff_s);
  // An ack only counts when a write is actually outstanding; a stray ack after
  // reset therefore does nothing.
  assign ack_s      = sdram_ack_i & wait_q;
  // End of download is judged only once no SDRAM write is outstanding.
  assign end_now_s  = loading_s & ~wait_q & (fall_s | (end_pend_q & ~start_s));
  assign complete_s = (exp_q >= TOTAL);
  assign rom_off_s  = dl_addr_i - SCR_END;
  assign rom_hit_s  = (rom_off_s < ROM_LEN);

  // State register and download-edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= dl_active_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = st_eff_s;
    if (overrun_s || bad_s) begin
      state_d = ST_ERR;
    end else if (end_now_s) begin
      state_d = complete_s ? ST_DONE : ST_ERR;
    end else if (good_s && (st_eff_s == ST_HEADER) && (exp_eff_s == HDR_LAST)) begin
      state_d = ST_SCREEN;
    end else if (ack_s && (st_eff_s == ST_SCREEN) && (exp_q == SCR_END)) begin
      // leave SCREEN only once the final image byte has been acknowledged
      state_d = ST_ROM;
    end else begin
      state_d = st_eff_s;
    end
  end

  // Output and datapath next-value logic
  always_comb begin
    exp_d        = exp_eff_s;
    wait_d       = wait_q;
    end_pend_d   = start_s ? 1'b0 : end_pend_q;
    sdram_we_d   = 1'b0;
    sdram_addr_d = sdram_addr_q;
    sdram_din_d  = sdram_din_q;
    rom_we_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    mcuid_d      = mcuid_q;
    joy_d        = joy_q;
    cfg_valid_d  = start_s ? 1'b0 : cfg_valid_q;
    err_d        = start_s ? 2'd0 : err_q;

    if (ack_s) begin
      wait_d = 1'b0;
    end else begin
      wait_d = wait_q;
    end

    // dl_active fell with a write still outstanding: remember it and judge
    // completion after the ack has been consumed.
    if (fall_s && loading_s && wait_q) begin
      end_pend_d = 1'b1;
    end else begin
      end_pend_d = end_pend_d;
    end

    if (end_now_s) begin
      end_pend_d  = 1'b0;
      cfg_valid_d = complete_s;
      err_d       = complete_s ? 2'd0 : 2'd2;
    end else if (overrun_s) begin
      err_d = 2'd3;
    end else if (bad_s) begin
      err_d = 2'd1;
    end else begin
      err_d = err_d;
    end

    if (good_s) begin
      exp_d = (exp_eff_s == EXP_MAX) ? EXP_MAX : exp_eff_s + 25'd1;
      case (st_eff_s)
        ST_HEADER: begin
          if (exp_eff_s == 25'd0) begin
            mcuid_d = dl_data_i;
          end else begin
            mcuid_d = mcuid_q;
          end
          for (int i = 0; i < 12; i++) begin
            if (exp_eff_s == 25'(i + 1)) begin
              joy_d[8*i +: 8] = dl_data_i;
            end else begin
              joy_d[8*i +: 8] = joy_q[8*i +: 8];
            end
          end
        end
        ST_SCREEN: begin
          sdram_we_d   = 1'b1;
          sdram_addr_d = dl_addr_i;
          sdram_din_d  = dl_data_i;
          wait_d       = 1'b1;
        end
        ST_ROM: begin
          // bytes beyond the ROM size are swallowed, exp still advances
          if (rom_hit_s) begin
            rom_we_d   = 1'b1;
            rom_addr_d = rom_off_s[11:0];
            rom_data_d = dl_data_i;
          end else begin
            rom_we_d = 1'b0;
          end
        end
        default: begin
          exp_d = exp_d;
        end
      endcase
    end else begin
      exp_d = exp_d;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q        <= 25'd0;
      wait_q       <= 1'b0;
      end_pend_q   <= 1'b0;
      sdram_we_q   <= 1'b0;
      sdram_addr_q <= 25'd0;
      sdram_din_q  <= 8'd0;
      rom_we_q     <= 1'b0;
      rom_addr_q   <= 12'd0;
      rom_data_q   <= 8'd0;
      mcuid_q      <= 8'd0;
      joy_q        <= 96'd0;
      cfg_valid_q  <= 1'b0;
      err_q        <= 2'd0;
    end else begin
      exp_q        <= exp_d;
      wait_q       <= wait_d;
      end_pend_q   <= end_pend_d;
      sdram_we_q   <= sdram_we_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_din_q  <= sdram_din_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      mcuid_q      <= mcuid_d;
      joy_q        <= joy_d;
      cfg_valid_q  <= cfg_valid_d;
      err_q        <= err_d;
    end
  end

  assign dl_wait_o    = wait_q;
  assign sdram_we_o   = sdram_we_q;
  assign sdram_addr_o = sdram_addr_q;
  assign sdram_din_o  = sdram_din_q;
  assign rom_we_o     = rom_we_q;
  assign rom_addr_o   = rom_addr_q;
  assign rom_data_o   = rom_data_q;
  assign mcuid_o      = mcuid_q;
  assign joy_cfg_o    = joy_q;
  assign cfg_valid_o  = cfg_valid_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_gnw_loader.sv
// Directed bench for gnw_loader with a small geometry: 13-byte header,
// 2x16-byte image (addresses 13..44), 8-byte ROM (addresses 45..52).
module tb_gnw_loader;

  localparam int SS = 16;
  localparam int HB = 13;
  localparam int RB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [24:0] dl_addr = 25'd0;
  logic [7:0]  dl_data = 8'd0;
  logic        dl_wait;
  logic        sdram_we;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_din;
  logic        sdram_ack;
  logic        auto_ack = 1'b0;
  logic        man_ack = 1'b0;
  logic        rom_we;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  mcuid;
  logic [95:0] joy_cfg;
  logic        cfg_valid;
  logic [1:0]  err;

  assign sdram_ack = auto_ack | man_ack;

  gnw_loader #(.SCREENSIZE(SS), .HDR_BYTES(HB), .ROM_BYTES(RB)) dut (
    .clk(clk), .rst_n(rst_n),
    .dl_active_i(dl_active), .dl_wr_i(dl_wr), .dl_addr_i(dl_addr), .dl_data_i(dl_data),
    .dl_wait_o(dl_wait),
    .sdram_we_o(sdram_we), .sdram_addr_o(sdram_addr), .sdram_din_o(sdram_din),
    .sdram_ack_i(sdram_ack),
    .rom_we_o(rom_we), .rom_addr_o(rom_addr), .rom_data_o(rom_data),
    .mcuid_o(mcuid), .joy_cfg_o(joy_cfg), .cfg_valid_o(cfg_valid), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SDRAM responder: ack two cycles after each sdram_we pulse when enabled
  bit ack_en = 1'b1;
  int ack_cnt = 0;
  always @(negedge clk) begin
    auto_ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt = ack_cnt - 1;
      if (ack_cnt == 0) auto_ack = 1'b1;
    end
    if (sdram_we && ack_en) ack_cnt = 2;
  end

  // Write monitor: logs every SDRAM and ROM write
  int          sd_n = 0;
  int          rom_n = 0;
  logic [24:0] sd_a [512];
  logic [7:0]  sd_d [512];
  logic [11:0] rm_a [512];
  logic [7:0]  rm_d [512];
  always @(negedge clk) begin
    if (sdram_we && sd_n < 512) begin
      sd_a[sd_n] = sdram_addr;
      sd_d[sd_n] = sdram_din;
      sd_n = sd_n + 1;
    end
    if (rom_we && rom_n < 512) begin
      rm_a[rom_n] = rom_addr;
      rm_d[rom_n] = rom_data;
      rom_n = rom_n + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  function automatic logic [7:0] pat(input int a, input int seed);
    return 8'((a * 7 + seed) & 255);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int a, input logic [7:0] d);
    int n;
    n = 0;
    while (dl_wait === 1'b1 && n < 100) begin
      step();
      n = n + 1;
    end
    if (n >= 100) check("wait_timeout", 96'(dl_wait), 96'd0);
    dl_wr = 1'b1;
    dl_addr = 25'(a);
    dl_data = d;
    step();
    dl_wr = 1'b0;
  endtask

  // whole download of nbytes, dl_active dropped right after the last byte
  task automatic full_dl(input int nbytes, input int seed);
    dl_active = 1'b1;
    for (int a = 0; a < nbytes; a++) send_byte(a, pat(a, seed));
    dl_active = 1'b0;
    repeat (8) step();
  endtask

  task automatic check_sd_seq(input string tag, input int base, input int cnt, input int seed);
    int bad;
    bad = 0;
    for (int i = 0; i < cnt; i++) begin
      if (sd_a[base + i] !== 25'(HB + i) || sd_d[base + i] !== pat(HB + i, seed)) bad = bad + 1;
    end
    check(tag, 96'(bad), 96'd0);
  endtask

  task automatic check_rom_seq(input string tag, input int base, input int cnt, input int seed);
    int bad;
    bad = 0;
    for (int i = 0; i < cnt; i++) begin
      if (rm_a[base + i] !== 12'(i) || rm_d[base + i] !== pat(HB + 2 * SS + i, seed)) bad = bad + 1;
    end
    check(tag, 96'(bad), 96'd0);
  endtask

  int sd0, rom0;
  logic [95:0] joy_exp;

  initial begin
    // reset state
    #1;
    check("rst_wait", 96'(dl_wait), 96'd0);
    check("rst_sdram_we", 96'(sdram_we), 96'd0);
    check("rst_rom_we", 96'(rom_we), 96'd0);
    check("rst_mcuid", 96'(mcuid), 96'd0);
    check("rst_joy", joy_cfg, 96'd0);
    check("rst_cfg_valid", 96'(cfg_valid), 96'd0);
    check("rst_err", 96'(err), 96'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // full file, first byte coincides with rising dl_active
    sd0 = sd_n;
    rom0 = rom_n;
    dl_active = 1'b1;
    for (int a = 0; a < HB + 2 * SS + RB; a++) begin
      send_byte(a, pat(a, 3));
      if (a == 0) check("mcuid_latency", 96'(mcuid), 96'(pat(0, 3)));
      if (a == HB) begin
        check("sdram_we_latency", 96'(sdram_we), 96'd1);
        check("wait_latency", 96'(dl_wait), 96'd1);
        check("sdram_addr_first", 96'(sdram_addr), 96'(HB));
      end
    end
    dl_active = 1'b0;
    repeat (8) step();
    check("full_sd_count", 96'(sd_n - sd0), 96'd32);
    check_sd_seq("full_sd_seq", sd0, 32, 3);
    check("full_rom_count", 96'(rom_n - rom0), 96'd8);
    check_rom_seq("full_rom_seq", rom0, 8, 3);
    check("full_cfg_valid", 96'(cfg_valid), 96'd1);
    check("full_err", 96'(err), 96'd0);
    check("full_mcuid", 96'(mcuid), 96'(pat(0, 3)));
    check("full_joy0", 96'(joy_cfg[7:0]), 96'(pat(1, 3)));
    joy_exp = 96'd0;
    for (int i = 0; i < 12; i++) joy_exp[8*i +: 8] = pat(i + 1, 3);
    check("full_joy_all", joy_cfg, joy_exp);

    // truncated after byte 40, ends with an SDRAM write outstanding
    sd0 = sd_n;
    rom0 = rom_n;
    full_dl(41, 5);
    check("short_err", 96'(err), 96'd2);
    check("short_cfg_valid", 96'(cfg_valid), 96'd0);
    check("short_rom_count", 96'(rom_n - rom0), 96'd0);
    check("short_sd_count", 96'(sd_n - sd0), 96'd28);
    check("short_wait", 96'(dl_wait), 96'd0);

    // address jump 20 -> 22
    sd0 = sd_n;
    dl_active = 1'b1;
    for (int a = 0; a <= 20; a++) send_byte(a, pat(a, 7));
    send_byte(22, pat(22, 7));
    check("jump_err", 96'(err), 96'd1);
    send_byte(23, pat(23, 7));
    repeat (4) step();
    check("jump_sd_count", 96'(sd_n - sd0), 96'd8);
    dl_active = 1'b0;
    repeat (4) step();
    check("jump_err_hold", 96'(err), 96'd1);
    check("jump_cfg_valid", 96'(cfg_valid), 96'd0);
    sd0 = sd_n;
    full_dl(HB + 2 * SS + RB, 11);
    check("fresh_err", 96'(err), 96'd0);
    check("fresh_cfg_valid", 96'(cfg_valid), 96'd1);
    check("fresh_sd_count", 96'(sd_n - sd0), 96'd32);
    check("fresh_mcuid", 96'(mcuid), 96'(pat(0, 11)));

    // overrun: strobe while dl_wait is high, then ack by hand
    ack_en = 1'b0;
    sd0 = sd_n;
    dl_active = 1'b1;
    for (int a = 0; a <= HB; a++) send_byte(a, pat(a, 1));
    check("ovr_wait_before", 96'(dl_wait), 96'd1);
    dl_wr = 1'b1;
    dl_addr = 25'(HB + 1);
    dl_data = pat(HB + 1, 1);
    step();
    dl_wr = 1'b0;
    check("ovr_err", 96'(err), 96'd3);
    check("ovr_wait_held", 96'(dl_wait), 96'd1);
    check("ovr_no_write", 96'(sdram_we), 96'd0);
    repeat (2) step();
    check("ovr_wait_no_ack", 96'(dl_wait), 96'd1);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    check("ovr_wait_fall", 96'(dl_wait), 96'd0);
    ack_en = 1'b1;
    dl_active = 1'b0;
    repeat (4) step();
    check("ovr_err_hold", 96'(err), 96'd3);
    check("ovr_cfg_valid", 96'(cfg_valid), 96'd0);
    check("ovr_sd_count", 96'(sd_n - sd0), 96'd1);

    // ROM region longer than ROM_BYTES
    rom0 = rom_n;
    full_dl(HB + 2 * SS + RB + 2, 9);
    check("romlong_rom_count", 96'(rom_n - rom0), 96'd8);
    check_rom_seq("romlong_rom_seq", rom0, 8, 9);
    check("romlong_cfg_valid", 96'(cfg_valid), 96'd1);
    check("romlong_err", 96'(err), 96'd0);

    // reset pulse mid-SCREEN with a write outstanding
    dl_active = 1'b1;
    for (int a = 0; a <= HB + 2; a++) send_byte(a, pat(a, 13));
    check("midrst_wait_before", 96'(dl_wait), 96'd1);
    rst_n = 1'b0;
    dl_active = 1'b0;
    #1;
    check("midrst_wait", 96'(dl_wait), 96'd0);
    check("midrst_sdram_we", 96'(sdram_we), 96'd0);
    check("midrst_sdram_addr", 96'(sdram_addr), 96'd0);
    check("midrst_mcuid", 96'(mcuid), 96'd0);
    check("midrst_joy", joy_cfg, 96'd0);
    check("midrst_cfg_err", 96'({cfg_valid, err}), 96'd0);
    step();
    step();
    rst_n = 1'b1;
    sd0 = sd_n;
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    repeat (3) step();
    check("late_ack_sd", 96'(sd_n - sd0), 96'd0);
    check("late_ack_wait", 96'(dl_wait), 96'd0);
    check("late_ack_err", 96'(err), 96'd0);
    sd0 = sd_n;
    rom0 = rom_n;
    full_dl(HB + 2 * SS + RB, 21);
    check("post_rst_cfg_valid", 96'(cfg_valid), 96'd1);
    check("post_rst_err", 96'(err), 96'd0);
    check("post_rst_sd_count", 96'(sd_n - sd0), 96'd32);
    check_sd_seq("post_rst_sd_seq", sd0, 32, 21);
    check("post_rst_rom_count", 96'(rom_n - rom0), 96'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
